// File: rtl/platform_pkg.sv
// Shared types and constants for the platform store/scroller.
package platform_pkg;

    localparam int unsigned NUM_PLAT = 8;
    localparam int unsigned PLAT_W   = 64;
    localparam int unsigned PLAT_H   = 8;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SPACING  = 60;
    localparam int unsigned SCREEN_H = NUM_PLAT * SPACING;
    localparam int unsigned X_SPAN   = SCREEN_W - PLAT_W;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned IDX_W    = $clog2(NUM_PLAT);
    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned LFSR_W   = 16;

    // Fibonacci taps 16,14,13,11 expressed as a mask on bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {IDLE, UPDATE} state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } plat_t;

    function automatic logic [COORD_W-1:0] reset_x(input int unsigned i);
        return COORD_W'(i * 72);
    endfunction

    function automatic logic [COORD_W-1:0] reset_y(input int unsigned i);
        return COORD_W'(i * SPACING);
    endfunction

endpackage

// File: rtl/platform_gen_if.sv
// Query/scroll bus between the game logic and the platform store.
interface platform_gen_if;
    import platform_pkg::*;

    logic               frame_clk;
    logic [COORD_W-1:0] scroll;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic [COORD_W-1:0] FootX;
    logic [COORD_W-1:0] FootY;
    logic               plat_on;
    logic               land;
    logic [COORD_W-1:0] land_y;
    logic               busy;
    logic [SCORE_W-1:0] score;

    modport master (
        output frame_clk, scroll, DrawX, DrawY, FootX, FootY,
        input  plat_on, land, land_y, busy, score
    );

    modport slave (
        input  frame_clk, scroll, DrawX, DrawY, FootX, FootY,
        output plat_on, land, land_y, busy, score
    );

endinterface

// File: rtl/platform_hit.sv
// Combinational box test of one point against one platform slot.
module platform_hit
    import platform_pkg::*;
(
    input  plat_t              slot_i,
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    output logic               hit_c
);

    // Right/bottom edges one bit wider so slots near the edge never wrap
    logic [COORD_W:0] x_end_c;
    logic [COORD_W:0] y_end_c;

    assign x_end_c = {1'b0, slot_i.x} + (COORD_W+1)'(PLAT_W);
    assign y_end_c = {1'b0, slot_i.y} + (COORD_W+1)'(PLAT_H);

    assign hit_c = (px_i >= slot_i.x) && ({1'b0, px_i} < x_end_c) &&
                   (py_i >= slot_i.y) && ({1'b0, py_i} < y_end_c);

endmodule

// File: rtl/platform_gen.sv
// Platform slot store: per-frame scroll/respawn plus pixel and foot hit queries.
// Optional score counter enabled by defining PLATFORM_GEN_SCORE_EN.
module platform_gen
    import platform_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset_n,
    platform_gen_if.slave  bus
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [COORD_W-1:0]  s_q, s_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [2:0]          fsync_q;
    logic                frame_ev_q;
    logic                busy_q;
    plat_t               slot_q [NUM_PLAT];
    plat_t               slot_wr_c;
    logic                slot_we_c;
    logic [COORD_W:0]    yn_c;
    logic [COORD_W-1:0]  rnd_c;
    logic [NUM_PLAT-1:0] pix_hit_c, foot_hit_c;
    logic                plat_on_q, land_q;
    logic [COORD_W-1:0]  land_y_q, land_y_c;

    // Two sync stages on VGA_VS, then a registered rising-edge detect
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync_q    <= '0;
            frame_ev_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            fsync_q    <= {fsync_q[1:0], bus.frame_clk};
            frame_ev_q <= fsync_q[1] & ~fsync_q[2];
            lfsr_q     <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign yn_c  = {1'b0, slot_q[idx_q].y} + {1'b0, s_q};
    assign rnd_c = lfsr_q[COORD_W-1:0];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        s_d       = s_q;
        slot_we_c = 1'b0;
        slot_wr_c = slot_q[idx_q];
        case (state_q)
            IDLE: begin
                if (frame_ev_q) begin
                    s_d     = (bus.scroll > COORD_W'(SPACING - 1)) ? COORD_W'(SPACING - 1) : bus.scroll;
                    idx_d   = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                slot_we_c = 1'b1;
                if (yn_c >= (COORD_W+1)'(SCREEN_H)) begin
                    slot_wr_c.y = COORD_W'(yn_c - (COORD_W+1)'(SCREEN_H));
                    slot_wr_c.x = (rnd_c <= COORD_W'(X_SPAN)) ? rnd_c : rnd_c - COORD_W'(X_SPAN);
                end else begin
                    slot_wr_c.y = yn_c[COORD_W-1:0];
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_PLAT - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_PLAT; i++) begin
                slot_q[i] <= '{x: reset_x(i), y: reset_y(i)};
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            busy_q  <= (state_d == UPDATE);
            if (slot_we_c) begin
                slot_q[idx_q] <= slot_wr_c;
            end
        end
    end

`ifdef PLATFORM_GEN_SCORE_EN
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W:0]   score_sum_c;

    assign score_sum_c = {1'b0, score_q} + (SCORE_W+1)'(s_d);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q <= '0;
        end else if ((state_q == IDLE) && frame_ev_q) begin
            score_q <= score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif

    for (genvar g = 0; g < NUM_PLAT; g++) begin : g_slot
        platform_hit u_pix_hit (
            .slot_i (slot_q[g]),
            .px_i   (bus.DrawX),
            .py_i   (bus.DrawY),
            .hit_c  (pix_hit_c[g])
        );
        platform_hit u_foot_hit (
            .slot_i (slot_q[g]),
            .px_i   (bus.FootX),
            .py_i   (bus.FootY),
            .hit_c  (foot_hit_c[g])
        );
    end

    // Walk from the top index down so the lowest-index hit wins
    always_comb begin
        land_y_c = '0;
        for (int i = int'(NUM_PLAT) - 1; i >= 0; i--) begin
            if (foot_hit_c[i]) begin
                land_y_c = slot_q[i].y;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            plat_on_q <= 1'b0;
            land_q    <= 1'b0;
            land_y_q  <= '0;
        end else begin
            plat_on_q <= |pix_hit_c;
            land_q    <= |foot_hit_c;
            land_y_q  <= land_y_c;
        end
    end

    assign bus.plat_on = plat_on_q;
    assign bus.land    = land_q;
    assign bus.land_y  = land_y_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_platform_gen.sv
// Directed self-checking bench for platform_gen (scroll, respawn, hit queries, reset).
module tb_platform_gen;
    import platform_pkg::*;

    logic Clk;
    logic Reset_n;
    platform_gen_if bus();

    platform_gen dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int checks;
    int failures;

    // Reference LFSR, free-running from the seed like the design's
    logic [15:0] m;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m <= 16'hACE1;
        else          m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    logic [9:0] exp_x [8];
    logic [9:0] exp_y [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slots(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_x%0d", tag, i), 32'(dut.slot_q[i].x), 32'(exp_x[i]));
            chk($sformatf("%s_y%0d", tag, i), 32'(dut.slot_q[i].y), 32'(exp_y[i]));
        end
    endtask

    task automatic set_reset_exp();
        for (int i = 0; i < 8; i++) begin
            exp_x[i] = 10'(i * 72);
            exp_y[i] = 10'(i * 60);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic exp, input string tag);
        @(negedge Clk);
        bus.DrawX = x;
        bus.DrawY = y;
        @(negedge Clk);
        chk(tag, 32'(bus.plat_on), 32'(exp));
    endtask

    task automatic foot(input logic [9:0] x, input logic [9:0] y,
                        input logic exp_l, input logic [9:0] exp_ly, input string tag);
        @(negedge Clk);
        bus.FootX = x;
        bus.FootY = y;
        @(negedge Clk);
        chk({tag, "_land"}, 32'(bus.land), 32'(exp_l));
        chk({tag, "_land_y"}, 32'(bus.land_y), 32'(exp_ly));
    endtask

    // mode 0: plain frame; 1: re-trigger frame_clk mid-busy; 2: assert reset on the 4th busy cycle
    task automatic run_frame(input logic [9:0] scr, input int mode,
                             output int lat, output int cnt, output logic [15:0] cap);
        cap = '0;
        @(negedge Clk);
        bus.scroll    = scr;
        bus.frame_clk = 1'b1;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!bus.busy && lat < 10);
        cnt = 0;
        while (bus.busy && cnt < 20) begin
            if (cnt == 7) cap = m;
            if (mode == 1 && cnt == 1) bus.frame_clk = 1'b0;
            if (mode == 1 && cnt == 3) bus.frame_clk = 1'b1;
            if (mode == 2 && cnt == 3) begin
                Reset_n       = 1'b0;
                bus.frame_clk = 1'b0;
                return;
            end
            cnt++;
            @(negedge Clk);
        end
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    function automatic logic [9:0] respawn_x(input logic [15:0] l);
        logic [9:0] v;
        v = l[9:0];
        return (v <= 10'd576) ? v : v - 10'd576;
    endfunction

    int          lat, cnt, extra_busy;
    logic [15:0] cap;
    logic [15:0] exp_score;

    initial begin
        checks   = 0;
        failures = 0;
        Clk      = 1'b0;
        Reset_n  = 1'b0;
        bus.frame_clk = 1'b0;
        bus.scroll = '0;
        bus.DrawX  = '0;
        bus.DrawY  = '0;
        bus.FootX  = '0;
        bus.FootY  = '0;
        exp_score  = '0;

        // Reset state, sampled while reset is still held
        repeat (3) @(negedge Clk);
        set_reset_exp();
        chk_slots("rst");
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_plat_on", 32'(bus.plat_on), 0);
        chk("rst_land", 32'(bus.land), 0);
        chk("rst_land_y", 32'(bus.land_y), 0);
        Reset_n = 1'b1;

        // Pixel queries against reset layout, including box edges
        pix(10'd72,  10'd60, 1'b1, "pix_72_60");
        pix(10'd72,  10'd68, 1'b0, "pix_72_68");
        pix(10'd135, 10'd67, 1'b1, "pix_135_67");
        pix(10'd136, 10'd60, 1'b0, "pix_136_60");
        pix(10'd71,  10'd60, 1'b0, "pix_71_60");
        pix(10'd0,   10'd0,  1'b1, "pix_0_0");

        // Foot queries
        foot(10'd80,  10'd62,  1'b1, 10'd60,  "foot_80_62");
        foot(10'd80,  10'd68,  1'b0, 10'd0,   "foot_80_68");
        foot(10'd510, 10'd425, 1'b1, 10'd420, "foot_510_425");

        // Scroll by 10: latency, busy length, new positions
        run_frame(10'd10, 0, lat, cnt, cap);
        chk("scr10_latency", 32'(lat), 4);
        chk("scr10_busy_len", 32'(cnt), 8);
        for (int i = 0; i < 8; i++) exp_y[i] = 10'(i * 60 + 10);
        chk_slots("scr10");
`ifdef PLATFORM_GEN_SCORE_EN
        exp_score = 16'd10;
`endif
        chk("scr10_score", 32'(bus.score), 32'(exp_score));
        pix(10'd5, 10'd10, 1'b1, "scr10_pix_5_10");
        pix(10'd5, 10'd9,  1'b0, "scr10_pix_5_9");

        // Scroll of 0 still runs an update but changes nothing
        run_frame(10'd0, 0, lat, cnt, cap);
        chk("scr0_busy_len", 32'(cnt), 8);
        chk_slots("scr0");
        chk("scr0_score", 32'(bus.score), 32'(exp_score));

        // Clamp: 100 -> 59, slot 7 lands on 479 without respawn
        do_reset();
        set_reset_exp();
        exp_score = '0;
        run_frame(10'd100, 0, lat, cnt, cap);
        chk("clamp_busy_len", 32'(cnt), 8);
        for (int i = 0; i < 8; i++) exp_y[i] = 10'(i * 60 + 59);
        chk_slots("clamp");
`ifdef PLATFORM_GEN_SCORE_EN
        exp_score = 16'd59;
`endif
        chk("clamp_score", 32'(bus.score), 32'(exp_score));

        // Next frame pushes slot 7 off the bottom: respawn at top with LFSR X
        run_frame(10'd1, 0, lat, cnt, cap);
        for (int i = 0; i < 7; i++) exp_y[i] = 10'(i * 60 + 60);
        exp_y[7] = 10'd0;
        exp_x[7] = respawn_x(cap);
        chk_slots("respawn");
        chk("respawn_x_range", 32'(dut.slot_q[7].x <= 10'd576), 1);
`ifdef PLATFORM_GEN_SCORE_EN
        exp_score = 16'd60;
`endif
        chk("respawn_score", 32'(bus.score), 32'(exp_score));

        // A frame edge arriving during busy is dropped
        run_frame(10'd5, 1, lat, cnt, cap);
        chk("drop_busy_len", 32'(cnt), 8);
        extra_busy = 0;
        repeat (12) begin
            @(negedge Clk);
            if (bus.busy) extra_busy++;
        end
        chk("drop_no_second_update", 32'(extra_busy), 0);
        for (int i = 0; i < 8; i++) exp_y[i] = exp_y[i] + 10'd5;
        chk_slots("drop");
`ifdef PLATFORM_GEN_SCORE_EN
        exp_score = 16'd65;
`endif
        chk("drop_score", 32'(bus.score), 32'(exp_score));

        // Reset on the 4th busy cycle discards the partial update
        run_frame(10'd20, 2, lat, cnt, cap);
        #1;
        set_reset_exp();
        chk_slots("midrst");
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_score", 32'(bus.score), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        extra_busy = 0;
        repeat (12) begin
            @(negedge Clk);
            if (bus.busy) extra_busy++;
        end
        chk("midrst_after_busy", 32'(extra_busy), 0);
        chk_slots("midrst_after");

`ifdef PLATFORM_GEN_SCORE_EN
        // Score saturation: 1110*59 = 65490, one more frame clips at FFFF
        do_reset();
        for (int k = 0; k < 1110; k++) run_frame(10'd59, 0, lat, cnt, cap);
        chk("sat_pre_score", 32'(bus.score), 32'h0000FFD2);
        run_frame(10'd59, 0, lat, cnt, cap);
        chk("sat_score", 32'(bus.score), 32'h0000FFFF);
        run_frame(10'd59, 0, lat, cnt, cap);
        chk("sat_hold_score", 32'(bus.score), 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/platform_gen.md
# platform_gen

Platform store and scroller for the Doodle Jump datapath. It sits beside `jumplogic` and upstream of `color_mapper`:
- holds NUM_PLAT platform slots;
- once per frame, shifts them down by the scroll amount `jumplogic` requests, respawning any slot that leaves the bottom at the top with a pseudo-random X;
- answers per-pixel "platform here?" queries for the colour mapper and foot-collision queries for the jump logic.

## Interface
- NUM_PLAT, 8: number of platform slots; slot index width is $clog2(NUM_PLAT).
- PLAT_W, 64: platform width in pixels.
- PLAT_H, 8: platform height in pixels.
- SCREEN_W, 640: visible width.
- SPACING, 60: vertical slot pitch; NUM_PLAT*SPACING equals screen height (480).

- Clk  in  1  system clock (MAX10_CLK1_50 domain).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA_VS level; synchronised internally.
- scroll  in  10  pixels to move platforms down; sampled on the frame event.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- FootX, FootY  in  10 each  doodle foot point.
- plat_on  out  1  pixel (DrawX, DrawY) lies inside any platform.
- land  out  1  foot point lies inside any platform.
- land_y  out  10  top Y of the lowest-index hit slot; 0 when land=0.
- busy  out  1  scroll update in progress.
- score  out  16  accumulated scroll in pixels.

## Operation
- Slot state: X[i] and Y[i], 10 bits each, unsigned screen coordinates.
- Reset values: Y[i]=i*SPACING; X[i]=i*72; LFSR=16'hACE1; score=0; plat_on=land=busy=0; land_y=0; FSM in IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every Clk, including while busy.
- Frame event: two-flop synchroniser on frame_clk, then a rising-edge detect.
- FSM states:
  - IDLE: on a frame event, latch s = min(scroll, SPACING-1), clear the slot index, go to UPDATE.
  - UPDATE: process one slot per cycle.
    - yn = Y[i] + s, computed 11 bits wide.
    - If yn ≥ NUM_PLAT*SPACING: Y[i] = yn − NUM_PLAT*SPACING, and X[i] = L if L ≤ SCREEN_W−PLAT_W, else L − (SCREEN_W−PLAT_W), where L = LFSR[9:0].
    - Otherwise Y[i] = yn and X[i] is unchanged.
    - After slot NUM_PLAT−1, return to IDLE.
- Frame events arriving in UPDATE are dropped, with no queuing.
- scroll of 0 still runs UPDATE and changes nothing.
- Hit test: slot i contains (px,py) iff X[i] ≤ px < X[i]+PLAT_W and Y[i] ≤ py < Y[i]+PLAT_H. Compute X[i]+PLAT_W 11 bits wide so there is no wrap.
- plat_on: OR of the hit test over all slots using DrawX/DrawY.
- land: OR over all slots using FootX/FootY. land_y is Y of the lowest-index hit slot.
- While busy, slot contents are a mix of old and new values. Consumers sample land only when busy=0.

## Timing
- plat_on, land and land_y are registered with 1-Clk latency from DrawX/DrawY/FootX/FootY.
- Frame event: 3 Clk after the frame_clk rise (2 sync stages plus the edge register).
- busy rises the cycle after the frame event and stays high for exactly NUM_PLAT cycles. Slot i is written at the end of busy cycle i.
- Score updates in the same cycle that busy rises.
- Reset_n low mid-UPDATE restores all reset values immediately. The FSM returns to IDLE and the partial update is discarded.

## Configuration
- PLATFORM_GEN_SCORE_EN defined: score += s on each UPDATE entry, saturating at 16'hFFFF.
- Macro undefined: score is tied to 16'h0000 and no counter is built.

## Structure
- Package platform_pkg holds:
  - the state enum {IDLE, UPDATE};
  - the LFSR seed and tap constants;
  - the reset-X function (i*72);
  - the `plat_t` struct {x, y}.
- One sub-module, platform_hit: combinational box test of one point against one slot, returning a hit bit. Instantiate it twice per slot, once for the pixel query and once for the foot query.

## Test plan
- Reset: Reset_n=0 → Y = 0,60,…,420; X = 0,72,…,504; busy=0; score=0. One Clk after DrawX=72, DrawY=60 is presented, plat_on=1; at DrawY=68, plat_on=0.
- Scroll: frame_clk rise with scroll=10 → busy high for 8 cycles, then Y[0]=10 and Y[7]=430; score=10 with the macro defined.
- Clamp and respawn: scroll=100 → s=59 and Y[7]=479, no respawn. Next frame with scroll=1 → Y[7]=0, and new X[7] is ≤ 576 and matches the LFSR reference model.
- Collision: after reset, FootX=80, FootY=62 → land=1, land_y=60. FootX=80, FootY=68 → land=0, land_y=0.
- Reset mid-update: drop Reset_n on the 4th busy cycle → all slots show reset values the next cycle, busy=0, and no stale writes occur after release.
- Saturation (macro defined): force score to 16'hFFF0 and apply scroll=59 → score=16'hFFFF. A frame edge during busy produces no second update.
